exe_stage: RTL and testbench

Execute stage of the five-stage pipeline; sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register. It applies forwarding selects to both operands and store data, evaluates the ALU command and resolves branches. It also runs an iterative 32-cycle shift-add multiply that stalls the front of the pipeline while it runs.

---
 rtl/exe_pkg.sv | 42 ++++
 rtl/exe_stage_iter_mul.sv | 68 ++++++
 rtl/exe_stage.sv | 111 +++++++++++
 tb/tb_exe_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types, forwarding selects, MUL FSM states.
package exe_pkg;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEZ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JMP  = 2'b11;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam int MUL_ITER = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    // Select code 11 falls back to the ID/EX value.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] idex_val,
                                            input logic [31:0] mem_val, input logic [31:0] wb_val);
        case (sel)
            FWD_MEM: fwd_mux = mem_val;
            FWD_WB:  fwd_mux = wb_val;
            default: fwd_mux = idex_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_iter_mul.sv
// Iterative 32x32 shift-add multiplier, low 32 bits. Operands latched on start in IDLE,
// 32 BUSY cycles, product presented in DONE; start is ignored outside IDLE.
module iter_mul
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam logic [4:0] LAST_ITER = 5'(MUL_ITER - 1);

    mul_state_t  state_q;
    mul_state_t  state_d;
    logic [4:0]  count;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] prod;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_BUSY;
            MUL_BUSY: if (count == LAST_ITER) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            count   <= '0;
            prod    <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        prod   <= '0;
                        count  <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q == MUL_BUSY);
    assign done    = (state_q == MUL_DONE);
    assign product = prod;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, ALU, branch resolution; combinational except the optional MUL engine
// (EXE_MUL_EN), which holds stall for 33 cycles and bubbles the controls while it runs.
module exe_stage
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [3:0]  ex_cmd,
    input  logic [1:0]  branch_type,
    input  logic        wb_en_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] reg2,
    input  logic [4:0]  dst_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [1:0]  sel_st,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic [31:0] alu_result,
    output logic [31:0] st_val,
    output logic [4:0]  dst_out,
    output logic        wb_en_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        br_taken,
    output logic [31:0] br_addr,
    output logic        stall
);

    logic [31:0] a;
    logic [31:0] b;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        br_raw;
    logic        squash;

    assign a      = fwd_mux(sel_src1, val1, mem_fwd_val, wb_fwd_val);
    assign b      = fwd_mux(sel_src2, val2, mem_fwd_val, wb_fwd_val);
    assign st_val = fwd_mux(sel_st,   reg2, mem_fwd_val, wb_fwd_val);

`ifdef EXE_MUL_EN
    assign mul_start = (ex_cmd == CMD_MUL) && !mul_busy && !mul_done;

    iter_mul u_iter_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic unused_clk;
    assign unused_clk  = clk;
    assign mul_start   = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign stall = !rst && (mul_start || mul_busy);

    // In DONE the frozen ex_cmd is ignored and the product is presented.
    always_comb begin
        alu_result = '0;
        if (mul_done) begin
            alu_result = mul_product;
        end else begin
            case (ex_cmd)
                CMD_ADD: alu_result = a + b;
                CMD_SUB: alu_result = a - b;
                CMD_AND: alu_result = a & b;
                CMD_OR:  alu_result = a | b;
                CMD_NOR: alu_result = ~(a | b);
                CMD_XOR: alu_result = a ^ b;
                CMD_SLL: alu_result = a << b[4:0];
                CMD_SRA: alu_result = 32'($signed(a) >>> b[4:0]);
                CMD_SRL: alu_result = a >> b[4:0];
                CMD_MUL: alu_result = mul_product;
                default: alu_result = '0;
            endcase
        end
    end

    always_comb begin
        br_raw = 1'b0;
        case (branch_type)
            BR_BEZ:  br_raw = (a == 32'd0);
            BR_BNE:  br_raw = (a != st_val);
            BR_JMP:  br_raw = 1'b1;
            default: br_raw = 1'b0;
        endcase
    end

    assign squash        = rst || stall;
    assign br_taken      = br_raw && !squash;
    assign br_addr       = pc_in + {val2[29:0], 2'b00};
    assign dst_out       = dst_in;
    assign wb_en_out     = wb_en_in     && !squash;
    assign mem_read_out  = mem_read_in  && !squash;
    assign mem_write_out = mem_write_in && !squash;

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage; MUL sequences are exercised when EXE_MUL_EN is defined.
module tb_exe_stage;
    import exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [3:0]  ex_cmd;
    logic [1:0]  branch_type;
    logic        wb_en_in, mem_read_in, mem_write_in;
    logic [31:0] val1, val2, reg2;
    logic [4:0]  dst_in;
    logic [1:0]  sel_src1, sel_src2, sel_st;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic [31:0] alu_result, st_val, br_addr;
    logic [4:0]  dst_out;
    logic        wb_en_out, mem_read_out, mem_write_out, br_taken, stall;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .ex_cmd(ex_cmd), .branch_type(branch_type),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .val1(val1), .val2(val2), .reg2(reg2), .dst_in(dst_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_st(sel_st),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .alu_result(alu_result), .st_val(st_val), .dst_out(dst_out),
        .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .br_taken(br_taken), .br_addr(br_addr), .stall(stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] cmd, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp);
        ex_cmd = cmd; val1 = x; val2 = y;
        sel_src1 = FWD_IDEX; sel_src2 = FWD_IDEX;
        #1;
        chk(tag, alu_result, exp);
    endtask

`ifdef EXE_MUL_EN
    // Called in the accept cycle; walks the stall window scrambling mem_fwd_val each cycle.
    task automatic run_mul(input string tag, input logic [31:0] exp);
        int   n;
        logic bad;
        n = 0;
        bad = 1'b0;
        #1;
        while (stall === 1'b1 && n < 40) begin
            n++;
            if (wb_en_out !== 1'b0 || br_taken !== 1'b0) bad = 1'b1;
            step();
            mem_fwd_val = $urandom;
            #1;
        end
        chk({tag, "_stall_cycles"}, n, 33);
        chk({tag, "_bubble"}, {31'd0, bad}, 32'd0);
        chk({tag, "_result"}, alu_result, exp);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_in = 32'h0000_1000; ex_cmd = CMD_ADD; branch_type = BR_JMP;
        wb_en_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b1;
        val1 = 32'd1; val2 = 32'd2; reg2 = 32'd0; dst_in = 5'd7;
        sel_src1 = FWD_IDEX; sel_src2 = FWD_IDEX; sel_st = FWD_IDEX;
        mem_fwd_val = 32'd0; wb_fwd_val = 32'd0;
        step(); step();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_ctrl", {29'd0, wb_en_out, mem_read_out, mem_write_out}, 32'd0);
        chk("rst_alu", alu_result, 32'd3);
        chk("rst_dst", {27'd0, dst_out}, 32'd7);

        rst = 1'b0; branch_type = BR_NONE;
        #1;
        chk("ctrl_pass", {29'd0, wb_en_out, mem_read_out, mem_write_out}, 32'd7);

        step();
        val1 = 32'd5; val2 = 32'd9; sel_src1 = FWD_MEM; mem_fwd_val = 32'd100;
        #1;
        chk("add_fwd", alu_result, 32'd109);
        chk("add_stall", {31'd0, stall}, 32'd0);

        step();
        ex_cmd = CMD_ADD; val1 = 32'd3; sel_src1 = FWD_IDEX; val2 = 32'd3;
        reg2 = 32'd7; sel_st = FWD_WB; wb_fwd_val = 32'd3; branch_type = BR_BNE;
        #1;
        chk("bne_equal", {31'd0, br_taken}, 32'd0);
        chk("st_val_wb", st_val, 32'd3);
        wb_fwd_val = 32'd4;
        #1;
        chk("bne_differ", {31'd0, br_taken}, 32'd1);
        chk("br_addr", br_addr, 32'h0000_100C);
        sel_st = 2'b11;
        #1;
        chk("st_val_sel11", st_val, 32'd7);

        branch_type = BR_BEZ; val1 = 32'd9; sel_src1 = FWD_WB; wb_fwd_val = 32'd0;
        #1;
        chk("bez_zero", {31'd0, br_taken}, 32'd1);
        wb_fwd_val = 32'd1;
        #1;
        chk("bez_nonzero", {31'd0, br_taken}, 32'd0);
        branch_type = BR_JMP; pc_in = 32'hFFFF_FFFC; val2 = 32'd1;
        #1;
        chk("jmp_taken", {31'd0, br_taken}, 32'd1);
        chk("br_addr_wrap", br_addr, 32'd0);
        branch_type = BR_NONE;

        step();
        alu_vec("sra", CMD_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_vec("srl", CMD_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        alu_vec("sll_mask", CMD_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
        alu_vec("sub", CMD_SUB, 32'd5, 32'd9, 32'hFFFF_FFFC);
        alu_vec("add_wrap", CMD_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        alu_vec("and", CMD_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        alu_vec("or",  CMD_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        alu_vec("nor", CMD_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000);
        alu_vec("xor", CMD_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        alu_vec("undef_cmd", 4'b1111, 32'd6, 32'd7, 32'd0);

`ifdef EXE_MUL_EN
        step();
        ex_cmd = CMD_MUL; val1 = 32'd7; sel_src1 = FWD_IDEX; val2 = 32'd0;
        sel_src2 = FWD_MEM; mem_fwd_val = 32'hFFFF_FFFD; branch_type = BR_JMP;
        run_mul("mul_neg", 32'hFFFF_FFEB);
        step();
        chk("mul_b2b_accept", {31'd0, stall}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        #1;
        chk("mul_rst_stall", {31'd0, stall}, 32'd0);
        chk("mul_rst_br", {31'd0, br_taken}, 32'd0);
        step();
        rst = 1'b0; ex_cmd = CMD_ADD; branch_type = BR_NONE;
        val1 = 32'd20; val2 = 32'd22; sel_src1 = FWD_IDEX; sel_src2 = FWD_IDEX;
        #1;
        chk("post_rst_add", alu_result, 32'd42);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        step();
        ex_cmd = CMD_MUL; val1 = 32'h0001_2345; val2 = 32'h0000_0100;
        run_mul("mul_pos", 32'h0123_4500);
`else
        step();
        ex_cmd = CMD_MUL; val1 = 32'd6; val2 = 32'd7; sel_src1 = FWD_IDEX; sel_src2 = FWD_IDEX;
        wb_en_in = 1'b1;
        #1;
        chk("mul_off_result", alu_result, 32'd0);
        chk("mul_off_stall", {31'd0, stall}, 32'd0);
        chk("mul_off_wb", {31'd0, wb_en_out}, 32'd1);
        step();
        chk("mul_off_stall_next", {31'd0, stall}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
